// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA port arbiter.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbState_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first masked request at or after ptr wins.
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [N-1:0]  cand;
  logic [PW-1:0] idx;

  always_comb begin
    cand   = req & mask;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!valid && cand[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA port; one access in flight, lock keeps bursts together.
module dma_arbiter
  import dma_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int DMA_LAT   = 1,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   lock,
  input  logic [N_REQ-1:0]   rw,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               dma_enable,
  output logic               dma_rw,
  output logic [AW-1:0]      dma_addr,
  output logic [DW-1:0]      dma_wdata,
  output logic               busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int LW = $clog2(DMA_LAT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  arbState_e      state, stateNxt;
  logic [PW-1:0]  ownerIdx, ownerNxt, ptr, ptrNxt, ptrAfter, pickPtr, grantIdx, pickIdx;
  logic [LW-1:0]  latCnt, latNxt;
  logic [BW-1:0]  burstCnt, burstNxt;
  logic [N_REQ-1:0] gntNxt, pickMask, pickOh;
  logic           pickValid, inWait, lastCyc, ownLocked, grantEn;
  logic           rwNxt;
  logic [AW-1:0]  addrNxt;
  logic [DW-1:0]  wdataNxt;

  function automatic logic [PW-1:0] ohToIdx(input logic [N_REQ-1:0] oh);
    ohToIdx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (oh[i]) ohToIdx = PW'(i);
  endfunction

  assign inWait    = (state == WAIT);
  assign lastCyc   = inWait && (latCnt == LW'(1));
  assign ptrAfter  = (ownerIdx == PW'(N_REQ - 1)) ? '0 : ownerIdx + 1'b1;
  // In the done cycle the owner is excluded unless the lock path re-grants it explicitly.
  assign pickPtr   = inWait ? ptrAfter : ptr;
  assign pickMask  = inWait ? ~gnt : '1;
  assign ownLocked = |(req & lock & gnt);
  assign pickIdx   = ohToIdx(pickOh);

  assign done       = lastCyc ? gnt : '0;
  assign dma_enable = (state == ISSUE);
  assign busy       = (state != IDLE);

  rr_picker #(.N(N_REQ), .PW(PW)) uPick (
    .req    (req),
    .mask   (pickMask),
    .ptr    (pickPtr),
    .winner (pickOh),
    .valid  (pickValid)
  );

  always_comb begin
    stateNxt = state;
    gntNxt   = gnt;
    ownerNxt = ownerIdx;
    ptrNxt   = ptr;
    latNxt   = latCnt;
    burstNxt = burstCnt;
    rwNxt    = dma_rw;
    addrNxt  = dma_addr;
    wdataNxt = dma_wdata;
    grantEn  = 1'b0;
    grantIdx = pickIdx;
    case (state)
      IDLE: begin
        if (pickValid) begin
          grantEn  = 1'b1;
          burstNxt = '0;
        end
      end
      ISSUE: begin
        latNxt   = LW'(DMA_LAT);
        stateNxt = WAIT;
      end
      WAIT: begin
        latNxt = latCnt - 1'b1;
        if (lastCyc) begin
          ptrNxt = ptrAfter;
          if (ownLocked && (int'(burstCnt) < MAX_BURST - 1)) begin
            grantEn  = 1'b1;
            grantIdx = ownerIdx;
            burstNxt = burstCnt + 1'b1;
          end else if (pickValid) begin
            grantEn  = 1'b1;
            burstNxt = '0;
          end else if (ownLocked) begin
            // burst cap reached but nobody else is waiting: keep the port, hold the count
            grantEn  = 1'b1;
            grantIdx = ownerIdx;
          end else begin
            gntNxt   = '0;
            stateNxt = IDLE;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
    if (grantEn) begin
      stateNxt         = ISSUE;
      ownerNxt         = grantIdx;
      gntNxt           = '0;
      gntNxt[grantIdx] = 1'b1;
      rwNxt            = rw[grantIdx];
      addrNxt          = addr[AW*grantIdx +: AW];
      wdataNxt         = wdata[DW*grantIdx +: DW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      ownerIdx  <= '0;
      ptr       <= '0;
      latCnt    <= '0;
      burstCnt  <= '0;
      dma_rw    <= 1'b0;
      dma_addr  <= '0;
      dma_wdata <= '0;
    end else begin
      state     <= stateNxt;
      gnt       <= gntNxt;
      ownerIdx  <= ownerNxt;
      ptr       <= ptrNxt;
      latCnt    <= latNxt;
      burstCnt  <= burstNxt;
      dma_rw    <= rwNxt;
      dma_addr  <= addrNxt;
      dma_wdata <= wdataNxt;
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench: two arbiter instances (DMA_LAT=1 and DMA_LAT=3) share one stimulus.
module tb_dma_arbiter;
  import dma_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, lock, rw;
  logic [47:0] addr, wdata;

  logic [2:0]  gntA, doneA, gntB, doneB;
  logic        enA, rwA, busyA, enB, rwB, busyB;
  logic [15:0] addrA, wdataA, addrB, wdataB;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  dma_arbiter #(.N_REQ(3), .AW(16), .DW(16), .DMA_LAT(1), .MAX_BURST(4)) dutA (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .rw(rw), .addr(addr), .wdata(wdata),
    .gnt(gntA), .done(doneA), .dma_enable(enA), .dma_rw(rwA), .dma_addr(addrA),
    .dma_wdata(wdataA), .busy(busyA)
  );

  dma_arbiter #(.N_REQ(3), .AW(16), .DW(16), .DMA_LAT(3), .MAX_BURST(4)) dutB (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .rw(rw), .addr(addr), .wdata(wdata),
    .gnt(gntB), .done(doneB), .dma_enable(enB), .dma_rw(rwB), .dma_addr(addrB),
    .dma_wdata(wdataB), .busy(busyB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    tick;
    reset = 1'b0;
    req = '0; lock = '0; rw = '0; addr = '0; wdata = '0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  logic [2:0] exp2 [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    reset = 1'b1;
    req = '0; lock = '0; rw = '0; addr = '0; wdata = '0;
    #3 reset = 1'b0;
    #1;
    chk("rst gnt",  32'(gntA),   0);
    chk("rst done", 32'(doneA),  0);
    chk("rst en",   32'(enA),    0);
    chk("rst busy", 32'(busyA),  0);
    chk("rst addr", 32'(addrA),  0);
    chk("rst rw",   32'(rwA),    0);
    tick;
    reset = 1'b1;

    // single read, DMA_LAT=1
    doReset;
    req = 3'b001; rw = 3'b001; addr[15:0] = 16'h0040;
    tick;
    chk("t1 gnt",  32'(gntA),  32'h1);
    chk("t1 en",   32'(enA),   1);
    chk("t1 addr", 32'(addrA), 32'h0040);
    chk("t1 rw",   32'(rwA),   32'(RW_READ));
    chk("t1 busy", 32'(busyA), 1);
    req = '0;
    tick;
    chk("t1 done",    32'(doneA), 32'h1);
    chk("t1 en off",  32'(enA),   0);
    chk("t1 gnt hold",32'(gntA),  32'h1);
    tick;
    chk("t1 idle busy", 32'(busyA), 0);
    chk("t1 idle gnt",  32'(gntA),  0);
    chk("t1 idle done", 32'(doneA), 0);
    chk("t1 addr held", 32'(addrA), 32'h0040);

    // contention, no lock: 0,1,2,0 with no idle bubble
    doReset;
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      tick;
      chk($sformatf("t2 en%0d", g),  32'(enA),  1);
      chk($sformatf("t2 gnt%0d", g), 32'(gntA), 32'(exp2[g]));
      tick;
      chk($sformatf("t2 done%0d", g), 32'(doneA), 32'(exp2[g]));
    end

    // lock with MAX_BURST=4: four grants to 1, then 2
    doReset;
    req = 3'b110; lock = 3'b010;
    for (int g = 0; g < 5; g++) begin
      tick;
      chk($sformatf("t3 en%0d", g),  32'(enA),  1);
      chk($sformatf("t3 gnt%0d", g), 32'(gntA), (g < 4) ? 32'h2 : 32'h4);
      tick;
    end

    // write path, DMA_LAT=3, inputs changed after grant
    doReset;
    req = 3'b100; rw = 3'b000; addr[47:32] = 16'h0100; wdata[47:32] = 16'hFFF3;
    tick;
    chk("t4 en",    32'(enB),    1);
    chk("t4 gnt",   32'(gntB),   32'h4);
    chk("t4 wdata", 32'(wdataB), 32'hFFF3);
    chk("t4 addr",  32'(addrB),  32'h0100);
    chk("t4 rw",    32'(rwB),    32'(RW_WRITE));
    addr[47:32] = 16'hBEEF; wdata[47:32] = 16'h1234; rw = 3'b100; req = '0;
    tick;
    chk("t4 done w1", 32'(doneB), 0);
    chk("t4 en w1",   32'(enB),   0);
    tick;
    chk("t4 done w2", 32'(doneB), 0);
    tick;
    chk("t4 done",       32'(doneB),  32'h4);
    chk("t4 addr kept",  32'(addrB),  32'h0100);
    chk("t4 wdata kept", 32'(wdataB), 32'hFFF3);
    tick;
    chk("t4 idle busy", 32'(busyB),  0);
    chk("t4 idle rw",   32'(rwB),    0);
    chk("t4 idle wd",   32'(wdataB), 32'hFFF3);

    // reset mid-WAIT after ptr has moved to 1
    doReset;
    req = 3'b001; rw = 3'b001; addr[15:0] = 16'h0AAA; wdata[15:0] = 16'h5555;
    tick;
    req = '0;
    tick; tick; tick;
    chk("t5 first done", 32'(doneB), 32'h1);
    tick;
    chk("t5 first idle", 32'(busyB), 0);
    req = 3'b100; addr[47:32] = 16'h0CCC;
    tick;
    chk("t5 gnt2", 32'(gntB), 32'h4);
    tick;
    reset = 1'b0;
    #1;
    chk("t5 rst gnt",   32'(gntB),   0);
    chk("t5 rst done",  32'(doneB),  0);
    chk("t5 rst en",    32'(enB),    0);
    chk("t5 rst rw",    32'(rwB),    0);
    chk("t5 rst addr",  32'(addrB),  0);
    chk("t5 rst wdata", 32'(wdataB), 0);
    chk("t5 rst busy",  32'(busyB),  0);
    req = 3'b011;
    tick;
    chk("t5 held done", 32'(doneB), 0);
    reset = 1'b1;
    tick;
    chk("t5 regrant gnt", 32'(gntB), 32'h1);
    chk("t5 regrant en",  32'(enB),  1);
    req = '0;
    tick; tick; tick;
    chk("t5 new done", 32'(doneB), 32'h1);

    // req dropped the cycle after grant: access completes once
    doReset;
    req = 3'b001; rw = 3'b000;
    tick;
    chk("t6 gnt", 32'(gntB), 32'h1);
    tick;
    req = '0;
    for (int c = 3; c <= 8; c++) begin
      tick;
      chk($sformatf("t6 done c%0d", c), 32'(doneB), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("t6 en c%0d", c),   32'(enB),   0);
    end
    chk("t6 busy", 32'(busyB), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Shares the single DMA port between the CNN layer clients: load_block reads, pool/conv layer writeback, and a spare requester. It replaces the ad-hoc enable/address/RW muxing the layer testbenches currently do. One access is in flight at a time, requesters are granted round-robin, and a lock input keeps bursts contiguous.

## Interface
- N_REQ, 3, number of requesters (≥2)
- AW, 16, DMA address width
- DW, 16, DMA data word width
- DMA_LAT, 1, cycles from DMA enable to access complete (≥1)
- MAX_BURST, 16, max consecutive locked grants to one requester while others wait
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester access request (level)
- lock  in  N_REQ  owner wants to keep the port after the current access
- rw  in  N_REQ  1 = read, 0 = write (DMA RW encoding)
- addr  in  N_REQ*AW  requester i at [AW*i +: AW]
- wdata  in  N_REQ*DW  requester i at [DW*i +: DW]
- gnt  out  N_REQ  one-hot; owner of the in-flight access
- done  out  N_REQ  one-cycle pulse to the owner when its access completes
- dma_enable  out  1  DMA enable
- dma_rw  out  1  DMA RW
- dma_addr  out  AW  DMA address
- dma_wdata  out  DW  DMA inputDATA
- busy  out  1  high in ISSUE/WAIT

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- IDLE: if any req is high, latch the winner index, its rw/addr/wdata, and set gnt. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: dma_enable=1 for exactly one cycle, with the latched fields on dma_rw/dma_addr/dma_wdata. Load lat_cnt=DMA_LAT. Go to WAIT.
- WAIT: decrement lat_cnt. The cycle in which lat_cnt reaches 1 is the done cycle:
  - done[owner]=1.
  - Re-arbitrate in the same cycle. If there is a winner, latch it and go to ISSUE. Otherwise clear gnt and go to IDLE.
- Arbitration is round-robin starting from ptr. After each completed access, ptr=owner+1 mod N_REQ.
- Lock: in the done cycle, if req[owner]&lock[owner] and burst_cnt<MAX_BURST-1, the owner wins regardless of ptr. burst_cnt increments on a locked re-grant and clears on any other grant.
- At burst_cnt limit: the owner is excluded if any other req is high. If no other req is high, the owner is granted and burst_cnt holds.
- Without lock, the owner's req is masked in its own done cycle. A requester can therefore drop req on seeing done with no duplicate access.
- Fields are latched at grant. Requester inputs may change after gnt without effect on the in-flight access.
- Dropping req after grant does not cancel the access. done is still pulsed.
- dma_rw, dma_addr and dma_wdata hold their last latched values in IDLE; only dma_enable qualifies them.
- Read data is not routed by this block. The DMA output bus goes straight to all clients, and the owner samples it on done.

## Timing
- Reset (async assert, sync deassert): state=IDLE, ptr=0, burst_cnt=0, lat_cnt=0. gnt, done, dma_enable, dma_rw, dma_addr, dma_wdata and busy are all 0.
- req high at edge k in IDLE: gnt and busy at k+1, dma_enable at k+1 (ISSUE), done at k+1+DMA_LAT.
- Back-to-back: the next dma_enable is at k+2+DMA_LAT. Throughput is one access per DMA_LAT+1 cycles, with no IDLE bubble.
- gnt is stable from ISSUE through the done cycle. It switches owner on the edge after done.
- Simultaneous requests: exactly one gnt bit is set. The lowest index at or after ptr wins.
- Reset mid-access: the access is aborted, no done pulse is issued, and all outputs go to 0 immediately.

## Structure
- Package dma_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - constants RW_READ=1'b1 and RW_WRITE=1'b0;
  - default AW/DW.
- Sub-module rr_picker is combinational: inputs req, mask and ptr; outputs a one-hot winner and a valid flag. The arbiter instantiates it once.
- The top level holds the FSM, latches, lat_cnt, burst_cnt and ptr.

## Test plan
- Single read: N_REQ=3, DMA_LAT=1, req[0] at cycle 0 with addr=16'h0040, rw=1 -> dma_enable cycle 1 with dma_addr=0040, dma_rw=1; done[0] cycle 2; back to IDLE cycle 3.
- Contention: req=3'b111 held at cycle 0, no lock -> grants in order 0,1,2,0; dma_enable cycles 1,3,5,7.
- Lock and cap: MAX_BURST=4, req[1]&lock[1] held, req[2] held -> four consecutive grants to 1, then grant 2.
- Write path: req[2], rw=0, addr=16'h0100, wdata=16'hFFF3, DMA_LAT=3 -> dma_wdata=FFF3 during ISSUE; done[2] 3 cycles after ISSUE; inputs changed after gnt have no effect.
- Reset mid-WAIT: DMA_LAT=3, assert reset one cycle after ISSUE -> all outputs 0 asynchronously; no done pulse; after release, a pending req is granted from ptr=0.
- Req drop: req[0] deasserted in the cycle after gnt -> access still completes, done[0] pulses, and no second access is issued.
